// File: rtl/alu_div_pkg.sv
// -----------------------------------------------------------------------------
// alu_div_pkg
// Shared types and constants for the sequential restoring divider.
//   state_t         : divider FSM states (IDLE, RUN, DONE)
//   DEF_DIVIDEND_W  : default dividend/quotient width
//   DEF_DIVISOR_W   : default divisor/remainder width
//   DEF_CNT_W       : iteration counter width for the default dividend width
//   cnt_width()     : iteration counter width for any dividend width
// -----------------------------------------------------------------------------
package alu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;
    localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W);

    // The counter runs DIVIDEND_W-1 down to 0; keep at least one bit.
    function automatic int cnt_width(input int dividend_w);
        return (dividend_w > 2) ? $clog2(dividend_w) : 1;
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// -----------------------------------------------------------------------------
// alu_div_step
// One combinational restoring-division iteration.
//   rem_in  [DIVISOR_W] : partial remainder before this step
//   bit_in  [1]         : next dividend bit (MSB first)
//   divisor [DIVISOR_W] : unsigned divisor
//   rem_out [DIVISOR_W] : partial remainder after this step
//   q_bit   [1]         : quotient bit produced by this step
// -----------------------------------------------------------------------------
module alu_div_step
    import alu_div_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W-1:0] rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W:0]   shifted;
    // One guard bit above the DIVISOR_W+1 trial width holds the borrow.
    logic [DIVISOR_W+1:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        q_bit   = ~diff[DIVISOR_W+1];
        rem_out = q_bit ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/alu_divider.sv
// -----------------------------------------------------------------------------
// alu_divider
// Sequential restoring divider, one quotient bit per clock, start/busy/done
// handshake. Unsigned dividend / unsigned divisor.
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   start     : request, sampled only when not busy (IDLE or DONE)
//   dividend  : numerator, captured on the accepted start edge
//   divisor   : denominator, captured on the accepted start edge
//   busy      : high while iterating (RUN)
//   done      : one-cycle pulse when results become valid
//   quotient  : result, held until the next operation completes
//   remainder : result, held until the next operation completes
//   div_zero  : divide-by-zero flag, held with the results
// Build option ALU_DIV_ZERO_CHECK_EN: a zero divisor leaves RUN after one
// cycle with div_zero=1, quotient all ones, remainder = low dividend bits.
// Without it div_zero is tied low and a zero divisor runs the full algorithm.
// -----------------------------------------------------------------------------
module alu_divider
    import alu_div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    localparam int               CNT_W    = cnt_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB,
    // so after DIVIDEND_W steps this register holds the quotient.
    logic [DIVIDEND_W-1:0] dvd_sh;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVISOR_W-1:0]  rem_part;
    logic [DIVISOR_W-1:0]  rem_step;
    logic                  q_bit;
    logic                  accept;
    logic                  zero_short;

    alu_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (rem_part),
        .bit_in  (dvd_sh[DIVIDEND_W-1]),
        .divisor (dsr),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

`ifdef ALU_DIV_ZERO_CHECK_EN
    assign zero_short = (dsr == '0);
`else
    assign zero_short = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (zero_short || (cnt == '0)) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            dvd_sh    <= '0;
            dsr       <= '0;
            rem_part  <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            cnt      <= LAST_CNT;
            dvd_sh   <= dividend;
            dsr      <= divisor;
            rem_part <= '0;
        end else if (state == RUN) begin
            if (zero_short) begin
                // Still on the first RUN cycle, so dvd_sh is the untouched dividend.
                quotient  <= '1;
                remainder <= dvd_sh[DIVISOR_W-1:0];
            end else begin
                cnt      <= cnt - CNT_W'(1);
                dvd_sh   <= {dvd_sh[DIVIDEND_W-2:0], q_bit};
                rem_part <= rem_step;
                if (cnt == '0) begin
                    quotient  <= {dvd_sh[DIVIDEND_W-2:0], q_bit};
                    remainder <= rem_step;
                end
            end
        end
    end

`ifdef ALU_DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          div_zero <= 1'b0;
        else if (accept)                       div_zero <= 1'b0;
        else if ((state == RUN) && zero_short) div_zero <= 1'b1;
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_divider.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_alu_divider
// Randomized and directed stimulus for alu_divider, compared every cycle
// against a behavioural schedule model, plus literal expectations for the
// directed scenarios. Honours ALU_DIV_ZERO_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_divider;

    localparam int DW = 8;
    localparam int SW = 4;
`ifdef ALU_DIV_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif
    localparam int ZLAT = ZC ? 1 : DW;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b1;
    logic          start    = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [SW-1:0] divisor  = '0;
    logic          busy, done, div_zero;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    bit abort    = 1'b0;

    alu_divider #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (SW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural model: an operation is a countdown of cycles until its
    // arithmetic result (plain / and %) appears on the outputs with done.
    int            m_left;
    bit            m_done, m_dz, p_dz;
    logic [DW-1:0] m_q, p_q;
    logic [SW-1:0] m_r, p_r;

    always @(posedge clk or negedge reset_n) begin : model
        bit acc, fin;
        if (!reset_n) begin
            m_left = 0; m_done = 0; m_q = '0; m_r = '0; m_dz = 0;
        end else begin
            acc = start && (m_left == 0);
            fin = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_q = p_q; m_r = p_r; m_dz = p_dz; fin = 1'b1;
                end
            end
            if (acc) begin
                m_dz = 1'b0;
                if (divisor == 0) begin
                    p_q = '1; p_r = SW'(dividend % (1 << SW)); p_dz = ZC; m_left = ZLAT;
                end else begin
                    p_q = dividend / divisor; p_r = SW'(dividend % divisor); p_dz = 1'b0; m_left = DW;
                end
            end
            m_done = fin;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({busy, done, div_zero, quotient, remainder} !==
                {(m_left > 0), m_done, m_dz, m_q, m_r}) begin
                failures++;
                $display("FAIL cycle %0d: busy/done/dz/q/r got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                         cyc, busy, done, div_zero, quotient, remainder,
                         (m_left > 0), m_done, m_dz, m_q, m_r);
            end
        end
    end

    task automatic expect_val(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Waits at most 40 cycles for a done pulse; returns the cycle it was seen.
    task automatic wait_done(input string name, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: done not seen within 40 cycles (got none, want pulse)", name);
        end
    endtask

    task automatic run_op(input string name, input logic [DW-1:0] a, input logic [SW-1:0] b,
                          input int exp_lat, input logic [DW-1:0] eq, input logic [SW-1:0] er,
                          input logic edz, input bit mid_start);
        int n_acc, busy_cyc, lat;
        bit seen;
        @(negedge clk); #1;
        start = 1'b1; dividend = a; divisor = b;
        n_acc = cyc + 1;
        seen = 1'b0; busy_cyc = 0; lat = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - n_acc;
            end
            #1;
            start = 1'b0;
            if (mid_start && i == 2) begin
                start = 1'b1; dividend = ~a; divisor = b + 4'd3;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done want done", name);
        end else begin
            expect_val({name, "_latency"}, lat, exp_lat);
            expect_val({name, "_busy_cycles"}, busy_cyc, exp_lat);
            expect_val({name, "_quotient"}, quotient, eq);
            expect_val({name, "_remainder"}, remainder, er);
            expect_val({name, "_div_zero"}, div_zero, edz);
        end
    endtask

    initial begin : stim
        int t1, t2, n0;
        bit ok;

        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        expect_val("reset_busy", busy, 0);
        expect_val("reset_done", done, 0);
        expect_val("reset_quotient", quotient, 0);
        expect_val("reset_remainder", remainder, 0);
        expect_val("reset_div_zero", div_zero, 0);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        run_op("div100_7", 8'd100, 4'd7, DW, 8'd14, 4'd2, 1'b0, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk); #1;
        start = 1'b1; dividend = 8'd255; divisor = 4'd1;
        n0 = cyc + 1;
        wait_done("b2b_first", t1, ok);
        if (ok) begin
            expect_val("b2b_first_latency", t1 - n0, DW);
            expect_val("b2b_first_quotient", quotient, 255);
            expect_val("b2b_first_remainder", remainder, 0);
            #1 dividend = 8'd5; divisor = 4'd9;
            wait_done("b2b_second", t2, ok);
            if (ok) begin
                expect_val("b2b_spacing", t2 - t1, DW + 1);
                expect_val("b2b_second_quotient", quotient, 0);
                expect_val("b2b_second_remainder", remainder, 5);
            end
        end
        #1 start = 1'b0;

        run_op("div_zero_a7", 8'hA7, 4'd0, ZLAT, 8'hFF, 4'd7, ZC, 1'b0);
        run_op("mid_start_100_7", 8'd100, 4'd7, DW, 8'd14, 4'd2, 1'b0, 1'b1);

        // Reset in the middle of RUN.
        @(negedge clk); #1;
        start = 1'b1; dividend = 8'd100; divisor = 4'd7;
        @(negedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        expect_val("midrst_busy", busy, 0);
        expect_val("midrst_done", done, 0);
        expect_val("midrst_quotient", quotient, 0);
        expect_val("midrst_remainder", remainder, 0);
        @(negedge clk);
        expect_val("midrst_no_done", done, 0);
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run_op("div200_13", 8'd200, 4'd13, DW, 8'd15, 4'd5, 1'b0, 1'b0);

        // Random per-cycle traffic, including zero divisors and async resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            start    = ($urandom_range(0, 3) == 0);
            dividend = DW'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? '0 : SW'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
        end
        @(negedge clk); #1 start = 1'b0;
        repeat (DW + 3) @(negedge clk);

        // Exhaustive sweep, back-to-back with start held high.
        #1 start = 1'b1;
        for (int a = 0; a < 256 && !abort; a++) begin
            for (int b = 1; b < 16 && !abort; b++) begin
                dividend = DW'(a);
                divisor  = SW'(b);
                wait_done("sweep", t1, ok);
                if (!ok) begin
                    abort = 1'b1;
                end else begin
                    if ((quotient !== DW'(a / b)) || (remainder !== SW'(a % b))) begin
                        failures++;
                        $display("FAIL sweep %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                                 a, b, quotient, remainder, a / b, a % b);
                    end
                    checks++;
                    #1;
                end
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
